// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the pipeline controller slice.
//   regbits_t     : 5-bit register index.
//   pctrl_state_t : controller states INIT / RUN / HALTED.
//   STALL_CNT_W   : width of the stall cycle counter.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  localparam int STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline datapath and its controller.
//   master : datapath side, drives hit/hazard/branch/halt status and
//            receives PC enable, latch enables/clears, halt and stall count.
//   slave  : controller side, the mirror image.
interface pipeline_ctrl_if;
  import cpu_types_pkg::*;

  // status from the datapath
  logic     ihit;
  logic     dhit;
  logic     mem_dREN;
  logic     mem_dWEN;
  logic     ex_dREN;
  regbits_t ex_wsel;
  regbits_t id_rs;
  regbits_t id_rt;
  logic     id_usert;
  logic     ex_pcsel;
  logic     wb_hlt;

  // control back to the datapath
  logic     pc_en;
  logic     ifid_en;
  logic     idex_en;
  logic     exmem_en;
  logic     memwb_en;
  logic     ifid_sRST;
  logic     idex_sRST;
  logic     exmem_sRST;
  logic     memwb_sRST;
  logic     halt;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_wsel,
           id_rs, id_rt, id_usert, ex_pcsel, wb_hlt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_sRST, idex_sRST, exmem_sRST, memwb_sRST, halt, stall_cnt
  );

  modport slave (
    input  ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_wsel,
           id_rs, id_rt, id_usert, ex_pcsel, wb_hlt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_sRST, idex_sRST, exmem_sRST, memwb_sRST, halt, stall_cnt
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detector (purely combinational).
//   ex_dREN  : load sitting in EX
//   ex_wsel  : destination register of that load
//   id_rs    : first source of the ID instruction
//   id_rt    : second register of the ID instruction
//   id_usert : id_rt is really read as a source
//   lu       : ID instruction must wait one cycle for the load
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     ex_dREN,
  input  regbits_t ex_wsel,
  input  regbits_t id_rs,
  input  regbits_t id_rt,
  input  logic     id_usert,
  output logic     lu
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (ex_wsel == id_rs);
  assign rt_match = id_usert & (ex_wsel == id_rt);

  // $zero is hardwired, so a load "writing" it can never feed anyone.
  assign lu = ex_dREN & (ex_wsel != '0) & (rs_match | rt_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline controller: PC enable, per-latch enable / sync clear,
// sticky halt and a saturating stall-cycle counter.
//   CLK, RST : clock and asynchronous active-high reset
//   bus      : pipeline_ctrl_if.slave (status in, control out)
// Control outputs are combinational from the state and current inputs;
// only the state and the stall counter are registered.
module pipeline_ctrl
  import cpu_types_pkg::*;
(
  input  logic           CLK,
  input  logic           RST,
  pipeline_ctrl_if.slave bus
);

  pctrl_state_t           state_reg, state_next;
  logic [STALL_CNT_W-1:0] stall_cnt_reg;

  logic       lu;
  logic       advance;
  logic       pc_en_c;
  // latch order in both vectors: [0]=IF/ID [1]=ID/EX [2]=EX/MEM [3]=MEM/WB
  logic [3:0] en_c;
  logic [3:0] srst_c;

  hazard_detect u_hazard (
    .ex_dREN  (bus.ex_dREN),
    .ex_wsel  (bus.ex_wsel),
    .id_rs    (bus.id_rs),
    .id_rt    (bus.id_rt),
    .id_usert (bus.id_usert),
    .lu       (lu)
  );

  // A pending data access without dhit freezes everything, just like ihit=0.
  assign advance = bus.ihit & (~(bus.mem_dREN | bus.mem_dWEN) | bus.dhit);

  always_comb begin
    pc_en_c    = 1'b0;
    en_c       = 4'b0000;
    srst_c     = 4'b0000;
    state_next = state_reg;
    case (state_reg)
      INIT: begin
        srst_c     = 4'b1111;
        state_next = RUN;
      end
      RUN: begin
        if (bus.wb_hlt) begin
          state_next = HALTED;
        end else if (!advance) begin
          // full freeze; branch/hazard are re-evaluated once memory answers
        end else if (bus.ex_pcsel) begin
          // the taken branch squashes IF/ID and ID/EX, so any load-use
          // hazard involving the squashed instruction is moot
          pc_en_c = 1'b1;
          en_c    = 4'b1111;
          srst_c  = 4'b0011;
        end else if (lu) begin
          // hold PC and IF/ID, push a bubble into ID/EX
          en_c   = 4'b1110;
          srst_c = 4'b0010;
        end else begin
          pc_en_c = 1'b1;
          en_c    = 4'b1111;
        end
      end
      HALTED: begin
        state_next = HALTED;
      end
      default: begin
        srst_c     = 4'b1111;
        state_next = INIT;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= INIT;
      stall_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == RUN) && !pc_en_c && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
    end
  end

  assign bus.pc_en      = pc_en_c;
  assign bus.ifid_en    = en_c[0];
  assign bus.idex_en    = en_c[1];
  assign bus.exmem_en   = en_c[2];
  assign bus.memwb_en   = en_c[3];
  assign bus.ifid_sRST  = srst_c[0];
  assign bus.idex_sRST  = srst_c[1];
  assign bus.exmem_sRST = srst_c[2];
  assign bus.memwb_sRST = srst_c[3];
  assign bus.halt       = (state_reg == HALTED);
  assign bus.stall_cnt  = stall_cnt_reg;

endmodule
